core_logic_param: RTL and testbench

CORE_LOGIC_PARAM -- requirements
Module: core_logic_param

---
 rtl/core_logic_param.sv | 215 +++++++++++++++++++++
 tb/tb_core_logic_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/core_logic_param.sv
// core_logic_param -- table-driven state machine with TAP-style control and BIST.
//
// Y steps through a writable transition-rule table. Rule i fires when it is
// valid, its src equals Y and (X_eff & mask) == val. The lowest firing index
// wins and Y takes that rule's dst; with no firing rule Y holds.
//
// Build option: define CORE_LOGIC_PARAM_BIST_EN to include the self-test
// engine (LFSR stimulus, MISR signature, step counter). Without it,
// RUNBIST_SELECT steps from external X exactly like INTEST_SELECT, and the
// BIST outputs are tied low.
//
// Ports
//   clk              sole clock
//   RESET_SM         synchronous active-high reset (clears Y, rule valids, BIST)
//   TLR              test-logic-reset: Y=0 and BIST idle; rules and MISR kept
//   X                external stimulus
//   RUNBIST_SELECT   run self-test (held for the whole run)
//   INTEST_SELECT    step from external X
//   SETSTATE_SELECT  load Y from ASSIGN_STATE
//   ASSIGN_STATE     value loaded by SETSTATE_SELECT
//   RULE_WE/ADDR/DATA  rule write port, RULE_DATA = {valid, src, mask, val, dst}
//   Y                current state
//   BIST_BUSY        high while the self-test runs
//   BIST_DONE        high once a full run completes, until RUNBIST_SELECT drops
//   SIGNATURE        MISR contents

// Per-rule match: decodes one table entry against the current state/stimulus.
module core_logic_param_rule #(
  parameter int STATE_W = 4,
  parameter int X_W     = 4
) (
  input  logic [2*STATE_W+2*X_W:0] rule,
  input  logic [STATE_W-1:0]       y,
  input  logic [X_W-1:0]           x,
  output logic                     hit,
  output logic [STATE_W-1:0]       dst
);
  logic               vld;
  logic [STATE_W-1:0] src;
  logic [X_W-1:0]     mask;
  logic [X_W-1:0]     val;

  assign {vld, src, mask, val, dst} = rule;
  assign hit = vld && (src == y) && ((x & mask) == val);
endmodule

module core_logic_param #(
  parameter int STATE_W   = 4,
  parameter int X_W       = 4,
  parameter int NUM_RULES = 32,
  parameter int BIST_LEN  = 64,
  localparam int AW       = $clog2(NUM_RULES),
  localparam int RULE_W   = 2*STATE_W + 2*X_W + 1
) (
  input  logic               clk,
  input  logic               RESET_SM,
  input  logic               TLR,
  input  logic [X_W-1:0]     X,
  input  logic               RUNBIST_SELECT,
  input  logic               INTEST_SELECT,
  input  logic               SETSTATE_SELECT,
  input  logic [STATE_W-1:0] ASSIGN_STATE,
  input  logic               RULE_WE,
  input  logic [AW-1:0]      RULE_ADDR,
  input  logic [RULE_W-1:0]  RULE_DATA,
  output logic [STATE_W-1:0] Y,
  output logic               BIST_BUSY,
  output logic               BIST_DONE,
  output logic [15:0]        SIGNATURE
);

  logic [NUM_RULES-1:0][RULE_W-1:0]  rule_q;
  logic [NUM_RULES-1:0]              hit;
  logic [NUM_RULES-1:0][STATE_W-1:0] dst;
  logic [STATE_W-1:0]                y_q;
  logic [STATE_W-1:0]                y_nxt;
  logic [STATE_W-1:0]                step_y;
  logic [X_W-1:0]                    x_eff;

  // One matcher per table entry.
  for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
    core_logic_param_rule #(.STATE_W(STATE_W), .X_W(X_W)) u_rule (
      .rule (rule_q[i]),
      .y    (y_q),
      .x    (x_eff),
      .hit  (hit[i]),
      .dst  (dst[i])
    );
  end

  // Lowest index wins: scan downward so the last assignment is the lowest hit.
  always_comb begin
    step_y = y_q;
    for (int i = NUM_RULES-1; i >= 0; i--)
      if (hit[i]) step_y = dst[i];
  end

`ifdef CORE_LOGIC_PARAM_BIST_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} bist_st_t;

  bist_st_t    st_q;
  logic [15:0] lfsr_q;
  logic [15:0] misr_q;
  logic [15:0] cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        bist_start;
  logic        bist_step;
  logic        bist_hold;
  logic [15:0] lfsr_nxt;
  logic [15:0] misr_nxt;

  // TLR and SETSTATE outrank BIST, so both gate start and step.
  assign bist_start = (st_q == S_IDLE) && RUNBIST_SELECT && !SETSTATE_SELECT && !TLR;
  assign bist_step  = (st_q == S_RUN)  && RUNBIST_SELECT && !SETSTATE_SELECT && !TLR;
  assign bist_hold  = (st_q == S_DONE) && RUNBIST_SELECT;

  assign x_eff    = bist_step ? lfsr_q[X_W-1:0] : X;
  // x^16+x^14+x^13+x^11+1, Fibonacci, shifting left.
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // The MISR compresses the state Y is about to take.
  assign misr_nxt = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
                  ^ {{(16-STATE_W){1'b0}}, step_y};

  always_comb begin
    y_nxt = y_q;
    if (TLR)                             y_nxt = '0;
    else if (SETSTATE_SELECT)            y_nxt = ASSIGN_STATE;
    else if (bist_start)                 y_nxt = '0;
    else if (bist_step)                  y_nxt = step_y;
    else if (INTEST_SELECT && !bist_hold) y_nxt = step_y;
  end

  always_ff @(posedge clk) begin
    if (RESET_SM) begin
      st_q   <= S_IDLE;
      lfsr_q <= 16'hACE1;
      misr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (TLR) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: if (bist_start) begin
          st_q   <= S_RUN;
          lfsr_q <= 16'hACE1;
          misr_q <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
        end
        S_RUN: if (bist_step) begin
          lfsr_q <= lfsr_nxt;
          misr_q <= misr_nxt;
          cnt_q  <= cnt_q + 16'd1;
          if (cnt_q == 16'(BIST_LEN-1)) begin
            st_q   <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          // Abort: RUNBIST dropped or SETSTATE took over; MISR is kept.
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
        end
        S_DONE: if (!RUNBIST_SELECT) begin
          st_q   <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign BIST_BUSY = busy_q;
  assign BIST_DONE = done_q;
  assign SIGNATURE = misr_q;
`else
  assign x_eff = X;

  always_comb begin
    y_nxt = y_q;
    if (TLR)                                  y_nxt = '0;
    else if (SETSTATE_SELECT)                 y_nxt = ASSIGN_STATE;
    else if (RUNBIST_SELECT || INTEST_SELECT) y_nxt = step_y;
  end

  assign BIST_BUSY = 1'b0;
  assign BIST_DONE = 1'b0;
  assign SIGNATURE = 16'h0000;
`endif

  // Table write lands at the edge, so a step in the write cycle sees old
  // contents. Reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (RESET_SM) begin
      y_q    <= '0;
      rule_q <= '0;
    end else begin
      y_q <= y_nxt;
      if (RULE_WE) rule_q[RULE_ADDR] <= RULE_DATA;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_core_logic_param.sv
module tb_core_logic_param;
  localparam int SW = 4, XW = 4, NR = 32, BL = 8, AW = 5, RW = 2*SW + 2*XW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET_SM, TLR, RUNBIST_SELECT, INTEST_SELECT, SETSTATE_SELECT, RULE_WE;
  logic [XW-1:0] X;
  logic [SW-1:0] ASSIGN_STATE, Y;
  logic [AW-1:0] RULE_ADDR;
  logic [RW-1:0] RULE_DATA;
  logic          BIST_BUSY, BIST_DONE;
  logic [15:0]   SIGNATURE;

  core_logic_param #(.STATE_W(SW), .X_W(XW), .NUM_RULES(NR), .BIST_LEN(BL)) dut (
    .clk(clk), .RESET_SM(RESET_SM), .TLR(TLR), .X(X),
    .RUNBIST_SELECT(RUNBIST_SELECT), .INTEST_SELECT(INTEST_SELECT),
    .SETSTATE_SELECT(SETSTATE_SELECT), .ASSIGN_STATE(ASSIGN_STATE),
    .RULE_WE(RULE_WE), .RULE_ADDR(RULE_ADDR), .RULE_DATA(RULE_DATA),
    .Y(Y), .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .SIGNATURE(SIGNATURE)
  );

  int total = 0, bad = 0;

  // Reference model: rule table as separate field arrays, plus BIST phase.
  logic          mv    [NR];
  logic [SW-1:0] msrc  [NR];
  logic [XW-1:0] mmask [NR];
  logic [XW-1:0] mval  [NR];
  logic [SW-1:0] mdst  [NR];
  logic [SW-1:0] my;
  int            ph;          // 0 idle, 1 run, 2 done
  int            mcnt;
  logic [15:0]   mlfsr, mmisr;

  function automatic logic [SW-1:0] nstep(logic [SW-1:0] y, logic [XW-1:0] x);
    for (int i = 0; i < NR; i++)
      if (mv[i] && msrc[i] == y && (x & mmask[i]) == mval[i]) return mdst[i];
    return y;
  endfunction

  function automatic logic [15:0] sh(logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  function automatic logic [RW-1:0] mk(logic v, logic [SW-1:0] s, logic [XW-1:0] m,
                                       logic [XW-1:0] vl, logic [SW-1:0] d);
    return {v, s, m, vl, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock from the current inputs, then clock the
  // DUT and compare every output.
  task automatic cyc();
    logic [SW-1:0] ny;
    if (RESET_SM) begin
      my = '0; ph = 0; mcnt = 0; mlfsr = 16'hACE1; mmisr = '0;
      for (int i = 0; i < NR; i++) mv[i] = 1'b0;
    end else begin
`ifdef CORE_LOGIC_PARAM_BIST_EN
      if (TLR) begin
        my = '0; ph = 0; mcnt = 0;
      end else if (SETSTATE_SELECT) begin
        my = ASSIGN_STATE;
        if (ph == 1) ph = 0;
      end else if (ph == 0 && RUNBIST_SELECT) begin
        my = '0; mlfsr = 16'hACE1; mmisr = '0; mcnt = 0; ph = 1;
      end else if (ph == 1 && RUNBIST_SELECT) begin
        ny    = nstep(my, mlfsr[XW-1:0]);
        mmisr = sh(mmisr) ^ 16'(ny);
        mlfsr = sh(mlfsr);
        my    = ny;
        mcnt++;
        if (mcnt == BL) ph = 2;
      end else if (!(ph == 2 && RUNBIST_SELECT)) begin
        ph = 0;
        if (INTEST_SELECT) my = nstep(my, X);
      end
`else
      if (TLR) my = '0;
      else if (SETSTATE_SELECT) my = ASSIGN_STATE;
      else if (INTEST_SELECT || RUNBIST_SELECT) my = nstep(my, X);
`endif
      if (RULE_WE) {mv[RULE_ADDR], msrc[RULE_ADDR], mmask[RULE_ADDR], mval[RULE_ADDR],
                    mdst[RULE_ADDR]} = RULE_DATA;
    end
    @(posedge clk);
    #1;
    chk("Y", 32'(Y), 32'(my));
    chk("BIST_BUSY", 32'(BIST_BUSY), 32'(ph == 1));
    chk("BIST_DONE", 32'(BIST_DONE), 32'(ph == 2));
    chk("SIGNATURE", 32'(SIGNATURE), 32'(mmisr));
  endtask

  task automatic idle_inputs();
    RESET_SM = 0; TLR = 0; RUNBIST_SELECT = 0; INTEST_SELECT = 0; SETSTATE_SELECT = 0;
    RULE_WE = 0; X = '0; ASSIGN_STATE = '0; RULE_ADDR = '0; RULE_DATA = '0;
  endtask

  task automatic wr(input int a, input logic [RW-1:0] d);
    RULE_WE = 1; RULE_ADDR = AW'(a); RULE_DATA = d;
  endtask

  initial begin
    bit rb_hold;
    idle_inputs();
    RESET_SM = 1;
    cyc(); cyc();
    RESET_SM = 0;

    // Single rule: X=1 from state 0 steps to 2, X=7 then holds.
    wr(0, mk(1, 0, 4'hF, 1, 2)); cyc(); RULE_WE = 0;
    INTEST_SELECT = 1; X = 1; cyc();
    chk("basic_step", 32'(Y), 32'd2);
    X = 7; cyc();
    chk("basic_hold", 32'(Y), 32'd2);

    // Write and step in the same cycle: old rule applies, new one next step.
    INTEST_SELECT = 0; wr(5, mk(1, 2, 0, 0, 4)); cyc();
    INTEST_SELECT = 1; X = 3; wr(5, mk(1, 2, 0, 0, 9)); cyc();
    chk("old_rule", 32'(Y), 32'd4);
    RULE_WE = 0; INTEST_SELECT = 0; SETSTATE_SELECT = 1; ASSIGN_STATE = 2; cyc();
    SETSTATE_SELECT = 0; INTEST_SELECT = 1; cyc();
    chk("new_rule", 32'(Y), 32'd9);

    // Lowest index wins.
    INTEST_SELECT = 0; SETSTATE_SELECT = 1; ASSIGN_STATE = 0;
    wr(0, mk(1, 0, 0, 0, 5)); cyc();
    SETSTATE_SELECT = 0; wr(1, mk(1, 0, 4'hF, 3, 9)); cyc();
    RULE_WE = 0; INTEST_SELECT = 1; X = 3; cyc();
    chk("priority", 32'(Y), 32'd5);

    // SETSTATE beats INTEST even with a matching rule; TLR beats SETSTATE.
    SETSTATE_SELECT = 1; ASSIGN_STATE = 0; cyc();
    ASSIGN_STATE = 9; cyc();
    chk("setstate", 32'(Y), 32'd9);
    ASSIGN_STATE = 0; cyc();
    ASSIGN_STATE = 9; TLR = 1; cyc();
    chk("tlr", 32'(Y), 32'd0);
    idle_inputs();

`ifdef CORE_LOGIC_PARAM_BIST_EN
    // Full BIST run with RUNBIST held; timing against edge count.
    for (int i = 0; i < 8; i++) begin
      wr(i, mk(1, SW'(i % 4), XW'($urandom), XW'($urandom), SW'($urandom_range(3))));
      cyc();
    end
    RULE_WE = 0;
    for (int rep = 0; rep < 2; rep++) begin
      RUNBIST_SELECT = 1;
      for (int k = 1; k <= 11; k++) begin
        cyc();
        chk("busy_edge", 32'(BIST_BUSY), 32'(k >= 1 && k <= 8));
        chk("done_edge", 32'(BIST_DONE), 32'(k >= 9));
      end
      RUNBIST_SELECT = 0; cyc();
      chk("done_clear", 32'(BIST_DONE), 32'd0);
    end
    // Abort after three RUN steps: signature frozen, no done.
    RUNBIST_SELECT = 1;
    for (int k = 0; k < 4; k++) cyc();
    RUNBIST_SELECT = 0; cyc();
    chk("abort_busy", 32'(BIST_BUSY), 32'd0);
    chk("abort_done", 32'(BIST_DONE), 32'd0);
    cyc(); cyc();
`else
    // Without BIST, RUNBIST steps from external X.
    SETSTATE_SELECT = 1; ASSIGN_STATE = 0; cyc();
    SETSTATE_SELECT = 0; RUNBIST_SELECT = 1; X = 3; cyc();
    chk("runbist_as_intest", 32'(Y), 32'd5);
    RUNBIST_SELECT = 0;
`endif

    // Reset with concurrent write: write dropped, matching X no longer steps.
    RESET_SM = 1; wr(0, mk(1, 0, 0, 0, 3)); cyc();
    RESET_SM = 0; RULE_WE = 0; INTEST_SELECT = 1; X = 0; cyc();
    chk("reset_wins", 32'(Y), 32'd0);
    chk("reset_sig", 32'(SIGNATURE), 32'd0);

    // Random traffic against the model.
    rb_hold = 0;
    for (int n = 0; n < 600; n++) begin
      RESET_SM        = ($urandom_range(99) == 0);
      TLR             = ($urandom_range(49) == 0);
      SETSTATE_SELECT = ($urandom_range(19) == 0);
      INTEST_SELECT   = ($urandom_range(3) != 0);
      if ($urandom_range(11) == 0) rb_hold = !rb_hold;
      RUNBIST_SELECT  = rb_hold;
      X               = XW'($urandom);
      ASSIGN_STATE    = SW'($urandom_range(3));
      RULE_WE         = ($urandom_range(3) == 0);
      RULE_ADDR       = AW'($urandom_range(7));
      RULE_DATA       = mk(1'($urandom_range(4) != 0), SW'($urandom_range(3)),
                           XW'($urandom), XW'($urandom), SW'($urandom_range(3)));
      RULE_DATA[2*XW+SW-1:SW] = RULE_DATA[2*XW+SW-1:SW] & {RULE_DATA[2*XW+SW-1:XW+SW], 4'hF};
      cyc();
    end
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
